// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, counter width and FSM states.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Wide enough for the largest legal latency (63).
    localparam int unsigned CNT_W = 6;

    typedef enum logic {
        StIdle,
        StRun
    } md_state_e;

endpackage

// File: rtl/md_core.sv
// Combinational mult/div datapath; result packs {hi, lo} as seen by the HI/LO registers.
module md_core
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic                      div_zero;
    logic                      div_ovf;
    logic        [WIDTH-1:0]   b_safe;
    logic signed [WIDTH-1:0]   quot_s;
    logic signed [WIDTH-1:0]   rem_s;
    logic        [WIDTH-1:0]   quot_u;
    logic        [WIDTH-1:0]   rem_u;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign div_zero = (b == '0);
    assign div_ovf  = (a == MOST_NEG) && (b == ALL_ONES);
    // Special cases are muxed in below; keep the divider itself away from them.
    assign b_safe   = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;

    assign quot_s = $signed(a) / $signed(b_safe);
    assign rem_s  = $signed(a) % $signed(b_safe);
    assign quot_u = a / b_safe;
    assign rem_u  = a % b_safe;

    always_comb begin
        result = '0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                if (div_zero)     result = {a, ALL_ONES};
                else if (div_ovf) result = {{WIDTH{1'b0}}, MOST_NEG};
                else              result = {rem_s, quot_s};
            end
            MD_DIVU: begin
                if (div_zero) result = {a, ALL_ONES};
                else          result = {rem_u, quot_u};
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; busy stalls HI/LO users upstream.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] result;

    md_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (result)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (!op[2]) begin
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                        cnt_d   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_d = StRun;
                    end else if (op == MD_MTHI) begin
                        hi_d = a;
                    end else if (op == MD_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            StRun: begin
                if (cnt_q == CNT_W'(1)) begin
                    {hi_d, lo_d} = result;
                    done_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected {hi,lo} queued at launch, checked at done.
module tb_md_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [WIDTH-1:0] cur_hi = '0;
    logic [WIDTH-1:0] cur_lo = '0;

    md_unit #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Returns at the negedge where done is seen, so the caller may launch in the done cycle.
    task automatic wait_done(input string tag, input int exp_busy);
        int   busy_cnt = 0;
        bit   seen = 0;
        logic [63:0] exp;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            a     = 32'hDEAD_BEEF;
            b     = 32'h0000_0007;
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) begin
                if (busy_cnt == 0) check_eq({tag, "_hold"}, {hi, lo}, {cur_hi, cur_lo});
                busy_cnt++;
            end
        end
        check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        if (!seen) begin
            check_eq({tag, "_timeout"}, 64'd0, 64'd1);
        end else if (exp_q.size() == 0) begin
            check_eq({tag, "_unexpected_done"}, 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            check_eq({tag, "_hilo"}, {hi, lo}, exp);
            check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            {cur_hi, cur_lo} = exp;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input int n, input logic [63:0] exp);
        exp_q.push_back(exp);
        launch(o, x, y);
        wait_done(tag, n);
    endtask

    initial begin
        int saw_done;
        #12;
        check_eq("reset_hilo", {hi, lo}, 64'd0);
        check_eq("reset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, MULT_N, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N,
               64'hFFFF_FFFE_0000_0001);

        // Asynchronous reset two cycles into a MULT.
        launch(3'd0, 32'd9, 32'd9);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("pre_reset_busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("async_reset_busy", 64'(busy), 64'd0);
        check_eq("async_reset_hilo", {hi, lo}, 64'd0);
        cur_hi = '0;
        cur_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check_eq("no_done_after_reset", 64'(saw_done), 64'd0);

        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, DIV_N, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 64'h0000_0000_8000_0000);
        run_op("divu_zero", 3'd3, 32'd100, 32'd0, DIV_N, 64'h0000_0064_FFFF_FFFF);
        run_op("div_zero", 3'd2, 32'hFFFF_FFF0, 32'd0, DIV_N, 64'hFFFF_FFF0_FFFF_FFFF);

        // MTHI: immediate, no busy.
        launch(3'd4, 32'h1234, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check_eq("mthi_hi", 64'(hi), 64'h1234);
        check_eq("mthi_busy", 64'(busy), 64'd0);
        cur_hi = 32'h1234;

        // Reserved op is a no-op.
        launch(3'd6, 32'h5555, 32'd1);
        @(negedge clk);
        start = 1'b0;
        check_eq("reserved_noop", {31'd0, busy, hi, lo}, {32'd0, cur_hi, cur_lo});

        // MULT with an MTLO attempted while busy; the MTLO must be dropped.
        exp_q.push_back(64'h0000_0000_0000_0006);
        launch(3'd0, 32'd2, 32'd3);
        @(negedge clk);
        check_eq("mult_busy_first", 64'(busy), 64'd1);
        launch(3'd5, 32'd5, 32'd0);
        wait_done("mult_ignore_mtlo", MULT_N - 1);

        // Launch in the done cycle: no bubble, full latency.
        run_op("divu_b2b", 3'd3, 32'd6, 32'd4, DIV_N, 64'h0000_0002_0000_0001);

        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the EX stage of the 5-stage pipeline.
- Adds configurable-latency MULT/MULTU/DIV/DIVU plus MTHI/MTLO, which the single-cycle ALU path cannot do.
- Drives `busy` so the conflict controller can stall any HI/LO-touching instruction in D.
- HI/LO are read combinationally by the MFHI/MFLO path in EX.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..63).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..63).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch request; qualifies `op`, sampled at clk rising edge.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6..7 reserved (no-op).
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  in  WIDTH  rt operand (divisor / multiplier).
- busy  out  1  high while a mult/div is in flight.
- done  out  1  one-cycle pulse in the cycle HI/LO take a mult/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, counter=0, state=IDLE. Any in-flight op is aborted and its result discarded.
- State machine has two states, IDLE and RUN.
- IDLE, start=1, op in 0..3:
  - Latch a, b and op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN. busy=1 from the next cycle.
- IDLE, start=1, op=4: hi<=a at the edge. op=5: lo<=a at the edge. No busy, no done.
- IDLE, start=1, op 6..7: ignored.
- RUN:
  - Counter decrements each cycle.
  - On the edge where counter reaches 1: write hi/lo, busy<=0, done<=1 for exactly one cycle, return to IDLE.
  - Net effect: busy is high for exactly N cycles after the start edge.
- `start` while busy=1: ignored, with no effect on hi, lo or the counter. Upstream guarantees no such issue; the unit is robust to it anyway.
- `start` in the cycle done=1: accepted, because the state is already IDLE. Back-to-back ops have no bubble.
- Results are computed only from the operands latched at start. Changing a/b during RUN has no effect. The internal algorithm (iterative or array) is free; only the timing above is visible.
- MULT: {hi,lo} = signed a × signed b, full 2·WIDTH product.
- MULTU: {hi,lo} = unsigned product.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of a.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV/DIVU): lo = all ones, hi = a. Full latency still applies, done still pulses.
- Signed overflow (DIV, a = most-negative, b = −1): lo = most-negative, hi = 0.
- hi/lo outputs hold their old values throughout RUN; no partial results are exposed.

Decomposition:
- Shared header gets the op codes (`MD_MULT` … `MD_MTLO`) as macro constants, alongside the existing opcode/funct defines.
- One natural sub-module: `md_core`, the combinational or iterative datapath taking op/a/b and producing the 2·WIDTH result.
- The FSM, counter and HI/LO registers stay in md_unit.

Test Plan:
1. Reset low mid-RUN (MULT started, 2 cycles in) → busy=0 and hi=lo=0 immediately (asynchronous), no done pulse afterwards.
2. MULT, a=0xFFFFFFFE (−2), b=3 → busy high for exactly 5 cycles, then done pulses; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
3. MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
4. DIV, a=−7 (0xFFFFFFF9), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
5. DIVU, a=100, b=0 → after 10 cycles lo=0xFFFFFFFF, hi=100.
6. Ordering and handshake sequence:
   - MTHI a=0x1234 → hi=0x1234 next cycle, busy stays 0.
   - Then MULT 2×3 with a second start during busy (MTLO a=5) → the MTLO is ignored; lo=6 at done.
   - Then start DIVU 6/4 in the done cycle → accepted with no bubble; lo=1, hi=2.
